// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage of the five-stage core.
// Owns the PC, drives the instruction-memory port, and holds the IF/ID
// register that feeds decode.
// Ports:
//   clk, rst_n          core clock; asynchronous active-low reset
//   stall               hold PC and IF/ID
//   redirect/_pc        taken branch/jump target (wins over stall)
//   imem_data/_rdy      instruction word at imem_addr, valid when rdy
//   imem_addr/_en       fetch address (= pc) and request
//   pc                  current PC
//   if_id_instr/_pc2    instruction to decode and its PC+2
//   if_id_valid         IF/ID holds a real instruction (0 = bubble)
//   err                 sticky flag, set by an odd redirect target
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic [15:0] imem_data,
  input  logic        imem_rdy,
  output logic [15:0] imem_addr,
  output logic        imem_en,
  output logic [15:0] pc,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc2,
  output logic        if_id_valid,
  output logic        err
);

  typedef enum logic {FETCH = 1'b0, HALTED = 1'b1} state_t;

  state_t      state, state_nx;
  logic [15:0] pc_nx, instr_nx, pc2_nx;
  logic        valid_nx, err_nx;
  logic [15:0] pc_inc;

  // 16-bit modulo increment: 16'hFFFE wraps to 16'h0000 silently
  assign pc_inc = pc + 16'd2;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = if_id_instr;
    pc2_nx   = if_id_pc2;
    valid_nx = if_id_valid;
    err_nx   = err;
    if (redirect) begin
      // redirect overrides stall and HALT; odd target is flagged, not fixed
      pc_nx    = redirect_pc;
      instr_nx = NOP_INSTR;
      pc2_nx   = 16'h0000;
      valid_nx = 1'b0;
      state_nx = FETCH;
      if (redirect_pc[0]) err_nx = 1'b1;
    end else if (stall) begin
      // hold everything
    end else if (state == HALTED || !imem_rdy) begin
      // bubble per cycle while halted or waiting on memory
      instr_nx = NOP_INSTR;
      pc2_nx   = 16'h0000;
      valid_nx = 1'b0;
    end else begin
      instr_nx = imem_data;
      pc2_nx   = pc_inc;
      valid_nx = 1'b1;
      if (imem_data[15:11] == 5'b00000) state_nx = HALTED;  // HALT: PC freezes
      else                              pc_nx    = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc2   <= 16'h0000;
      if_id_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      if_id_instr <= instr_nx;
      if_id_pc2   <= pc2_nx;
      if_id_valid <= valid_nx;
      err         <= err_nx;
    end
  end

  assign imem_addr = pc;
  assign imem_en   = rst_n & (state == FETCH) & ~stall;

endmodule
